pipeline_crossfader: RTL and testbench

- N-way successor to the engine's two-pipeline mixer.
- Applies input gain to the incoming sample and output gain to the selected pipeline's output.
- Performs a timed linear crossfade over 2^fade_log2 output samples, from the current pipeline to any target pipeline.
- Sits between the dsp_engine FSM and the n_pipelines dsp_pipeline instances; driven by control_unit gain and swap strobes.

---
 rtl/pipeline_crossfader_pkg.sv | 11 +
 rtl/pipeline_crossfader_if.sv | 39 +++
 rtl/pipeline_crossfader_sat_scale.sv | 43 ++++
 rtl/pipeline_crossfader.sv | 169 ++++++++++++++++
 tb/tb_pipeline_crossfader.sv | 445 ++++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/pipeline_crossfader_pkg.sv
// Shared types and helpers for the N-way pipeline crossfader.
package pipeline_crossfader_pkg;

   typedef enum logic {StIdle, StFade} xfade_state_e;

   // Gain word is fixed point with gs integer bits; this is the code for 1.0.
   function automatic int unsigned unity_gain(input int unsigned dw, input int unsigned gs);
      return 32'd1 << (dw - 1 - gs);
   endfunction

endpackage

// File: rtl/pipeline_crossfader_if.sv
// Sample, gain and swap signals between the engine, the pipelines and the crossfader.
interface pipeline_crossfader_if #(
   parameter int unsigned DataWidth  = 16,
   parameter int unsigned NPipelines = 4
);
   localparam int unsigned TargetWidth = $clog2(NPipelines);

   logic [DataWidth-1:0]            in_sample;
   logic                            in_valid;
   logic [DataWidth-1:0]            in_sample_out;
   logic                            in_out_valid;
   logic [NPipelines*DataWidth-1:0] pipe_samples;
   logic                            pipes_valid;
   logic [DataWidth-1:0]            out_sample;
   logic                            out_valid;
   logic [DataWidth-1:0]            gain_data;
   logic                            set_input_gain;
   logic                            set_output_gain;
   logic                            swap_req;
   logic [TargetWidth-1:0]          swap_target;
   logic                            swap_rejected;
   logic                            swapping;
   logic [TargetWidth-1:0]          current_pipeline;

   modport master (
      output in_sample, in_valid, pipe_samples, pipes_valid, gain_data,
             set_input_gain, set_output_gain, swap_req, swap_target,
      input  in_sample_out, in_out_valid, out_sample, out_valid,
             swap_rejected, swapping, current_pipeline
   );

   modport slave (
      input  in_sample, in_valid, pipe_samples, pipes_valid, gain_data,
             set_input_gain, set_output_gain, swap_req, swap_target,
      output in_sample_out, in_out_valid, out_sample, out_valid,
             swap_rejected, swapping, current_pipeline
   );

endinterface

// File: rtl/pipeline_crossfader_sat_scale.sv
// Signed multiply by a fixed-point gain, arithmetic shift and saturate; one register stage.
module pipeline_crossfader_sat_scale #(
   parameter int unsigned DataWidth = 16,
   parameter int unsigned GainShift = 5
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 i_valid,
   input  logic [DataWidth-1:0] i_x,
   input  logic [DataWidth-1:0] i_g,
   output logic                 o_valid,
   output logic [DataWidth-1:0] o_y
);
   localparam int unsigned ProdWidth = 2 * DataWidth;
   localparam int unsigned Shift     = DataWidth - 1 - GainShift;

   logic signed [ProdWidth-1:0] w_x, w_g, w_p, w_r;
   logic        [DataWidth-1:0] w_sat;

   assign w_x = ProdWidth'($signed(i_x));
   assign w_g = ProdWidth'($signed(i_g));
   assign w_p = w_x * w_g;
   assign w_r = w_p >>> Shift;

   // Result fits only if all bits above the output sign bit match it.
   always_comb begin
      w_sat = w_r[DataWidth-1:0];
      if (w_r[ProdWidth-1:DataWidth-1] != {(DataWidth+1){w_r[ProdWidth-1]}}) begin
         w_sat = w_r[ProdWidth-1] ? {1'b1, {(DataWidth-1){1'b0}}} : {1'b0, {(DataWidth-1){1'b1}}};
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         o_valid <= 1'b0;
         o_y     <= '0;
      end else begin
         o_valid <= i_valid;
         if (i_valid) o_y <= w_sat;
      end
   end

endmodule

// File: rtl/pipeline_crossfader.sv
// Input/output gain stages and a timed linear crossfade between N pipeline outputs.
module pipeline_crossfader
   import pipeline_crossfader_pkg::*;
#(
   parameter int unsigned DataWidth  = 16,
   parameter int unsigned NPipelines = 4,
   parameter int unsigned GainShift  = 5,
   parameter int unsigned FadeLog2   = 8
) (
   input logic                 clk,
   input logic                 reset,
   pipeline_crossfader_if.slave bus
);
   localparam int unsigned TargetWidth = $clog2(NPipelines);
   localparam int unsigned AccWidth    = DataWidth + FadeLog2 + 1;
   localparam logic [DataWidth-1:0]       UnityGain = DataWidth'(unity_gain(DataWidth, GainShift));
   localparam logic [TargetWidth:0]       NPipesExt = (TargetWidth + 1)'(NPipelines);
   localparam logic signed [AccWidth-1:0] FadeLen   = AccWidth'(1 << FadeLog2);

   xfade_state_e           r_state;
   logic [TargetWidth-1:0] r_current, r_target;
   logic [FadeLog2-1:0]    r_k;
   logic                   r_swapping, r_swap_rejected;
   logic [DataWidth-1:0]   r_in_gain, r_out_gain;
   logic                   r_in_v;
   logic [DataWidth-1:0]   r_in_x, r_in_g;
   logic                   r_s0_v, r_s0_fade;
   logic [DataWidth-1:0]   r_s0_a, r_s0_b, r_s0_g;
   logic [FadeLog2-1:0]    r_s0_k;
   logic                   r_s1_v;
   logic [DataWidth-1:0]   r_s1_m, r_s1_g;

   logic [DataWidth-1:0]        w_pipes [NPipelines];
   logic                        w_target_oob;
   logic signed [AccWidth-1:0]  w_a_ext, w_b_ext, w_k_ext, w_fk_ext, w_acc;
   logic [DataWidth-1:0]        w_mix;

   for (genvar i = 0; i < NPipelines; i++) begin : g_pipes
      assign w_pipes[i] = bus.pipe_samples[i*DataWidth +: DataWidth];
   end

   assign w_target_oob = ({1'b0, bus.swap_target} >= NPipesExt);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state         <= StIdle;
         r_current       <= '0;
         r_target        <= '0;
         r_k             <= '0;
         r_swapping      <= 1'b0;
         r_swap_rejected <= 1'b0;
      end else begin
         r_swap_rejected <= 1'b0;
         unique case (r_state)
            StIdle: begin
               if (bus.swap_req) begin
                  if (w_target_oob) begin
                     r_swap_rejected <= 1'b1;
                  end else if (bus.swap_target != r_current) begin
                     r_target   <= bus.swap_target;
                     r_k        <= '0;
                     r_swapping <= 1'b1;
                     r_state    <= StFade;
                  end
               end
            end
            StFade: begin
               if (bus.swap_req) r_swap_rejected <= 1'b1;
               if (bus.pipes_valid) begin
                  if (r_k == {FadeLog2{1'b1}}) begin
                     r_current  <= r_target;
                     r_swapping <= 1'b0;
                     r_k        <= '0;
                     r_state    <= StIdle;
                  end else begin
                     r_k <= r_k + FadeLog2'(1);
                  end
               end
            end
            default: r_state <= StIdle;
         endcase
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_in_gain  <= UnityGain;
         r_out_gain <= UnityGain;
      end else begin
         if (bus.set_input_gain)  r_in_gain  <= bus.gain_data;
         if (bus.set_output_gain) r_out_gain <= bus.gain_data;
      end
   end

   // Gain registers are read before this edge's load, so a coincident sample keeps the old gain.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_in_v    <= 1'b0;
         r_in_x    <= '0;
         r_in_g    <= '0;
         r_s0_v    <= 1'b0;
         r_s0_fade <= 1'b0;
         r_s0_a    <= '0;
         r_s0_b    <= '0;
         r_s0_g    <= '0;
         r_s0_k    <= '0;
         r_s1_v    <= 1'b0;
         r_s1_m    <= '0;
         r_s1_g    <= '0;
      end else begin
         r_in_v <= bus.in_valid;
         if (bus.in_valid) begin
            r_in_x <= bus.in_sample;
            r_in_g <= r_in_gain;
         end
         r_s0_v <= bus.pipes_valid;
         if (bus.pipes_valid) begin
            r_s0_a    <= w_pipes[r_current];
            r_s0_b    <= w_pipes[r_target];
            r_s0_k    <= r_k;
            r_s0_fade <= (r_state == StFade);
            r_s0_g    <= r_out_gain;
         end
         r_s1_v <= r_s0_v;
         if (r_s0_v) begin
            r_s1_m <= r_s0_fade ? w_mix : r_s0_a;
            r_s1_g <= r_s0_g;
         end
      end
   end

   assign w_a_ext  = AccWidth'($signed(r_s0_a));
   assign w_b_ext  = AccWidth'($signed(r_s0_b));
   assign w_k_ext  = AccWidth'(r_s0_k);
   assign w_fk_ext = FadeLen - w_k_ext;
   assign w_acc    = w_a_ext * w_fk_ext + w_b_ext * w_k_ext;
   assign w_mix    = DataWidth'(w_acc >>> FadeLog2);

   pipeline_crossfader_sat_scale #(
      .DataWidth(DataWidth),
      .GainShift(GainShift)
   ) u_in_scale (
      .clk    (clk),
      .reset  (reset),
      .i_valid(r_in_v),
      .i_x    (r_in_x),
      .i_g    (r_in_g),
      .o_valid(bus.in_out_valid),
      .o_y    (bus.in_sample_out)
   );

   pipeline_crossfader_sat_scale #(
      .DataWidth(DataWidth),
      .GainShift(GainShift)
   ) u_out_scale (
      .clk    (clk),
      .reset  (reset),
      .i_valid(r_s1_v),
      .i_x    (r_s1_m),
      .i_g    (r_s1_g),
      .o_valid(bus.out_valid),
      .o_y    (bus.out_sample)
   );

   assign bus.swapping         = r_swapping;
   assign bus.swap_rejected    = r_swap_rejected;
   assign bus.current_pipeline = r_current;

endmodule

// File: tb/tb_pipeline_crossfader.sv
// Directed bench for pipeline_crossfader: 16-bit words, 3 pipelines, 4-sample fades.
module tb_pipeline_crossfader;
   localparam int unsigned DW = 16;
   localparam int unsigned NP = 3;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   n_checks = 0;
   int   n_errors = 0;
   logic signed [15:0] y;
   logic               v;

   always #5 clk = ~clk;

   pipeline_crossfader_if #(.DataWidth(DW), .NPipelines(NP)) bus ();

   pipeline_crossfader #(
      .DataWidth (DW),
      .NPipelines(NP),
      .GainShift (5),
      .FadeLog2  (2)
   ) dut (
      .clk  (clk),
      .reset(rst_n),
      .bus  (bus)
   );

   task automatic set_pipes(input logic [15:0] p0, input logic [15:0] p1, input logic [15:0] p2);
      bus.pipe_samples = {p2, p1, p0};
   endtask

   task automatic load_gains(input logic [15:0] g, input logic in_g, input logic out_g);
      @(negedge clk);
      bus.gain_data = g;
      bus.set_input_gain = in_g;
      bus.set_output_gain = out_g;
      @(negedge clk);
      bus.set_input_gain = 1'b0;
      bus.set_output_gain = 1'b0;
   endtask

   task automatic do_swap(input logic [1:0] tgt);
      @(negedge clk);
      bus.swap_req = 1'b1;
      bus.swap_target = tgt;
      @(negedge clk);
      bus.swap_req = 1'b0;
   endtask

   // One pipes_valid pulse; returns what appears three cycles later.
   task automatic pipe_shot(input logic swp, input logic [1:0] tgt,
                            output logic signed [15:0] ys, output logic vs);
      @(negedge clk);
      bus.pipes_valid = 1'b1;
      bus.swap_req = swp;
      bus.swap_target = tgt;
      @(negedge clk);
      bus.pipes_valid = 1'b0;
      bus.swap_req = 1'b0;
      @(negedge clk);
      @(negedge clk);
      ys = bus.out_sample;
      vs = bus.out_valid;
   endtask

   task automatic in_shot(input logic [15:0] x, output logic signed [15:0] ys, output logic vs);
      @(negedge clk);
      bus.in_sample = x;
      bus.in_valid = 1'b1;
      @(negedge clk);
      bus.in_valid = 1'b0;
      @(negedge clk);
      ys = bus.in_sample_out;
      vs = bus.in_out_valid;
   endtask

   task automatic test_reset();
      repeat (2) @(negedge clk);
      n_checks++;
      if (bus.out_sample !== 16'h0 || bus.out_valid !== 1'b0 || bus.in_sample_out !== 16'h0 ||
          bus.in_out_valid !== 1'b0) begin
         n_errors++;
         $display("FAIL reset_outputs got out=%h ov=%b in=%h iv=%b want all 0", bus.out_sample,
                  bus.out_valid, bus.in_sample_out, bus.in_out_valid);
      end
      n_checks++;
      if (bus.current_pipeline !== 2'd0 || bus.swapping !== 1'b0 || bus.swap_rejected !== 1'b0) begin
         n_errors++;
         $display("FAIL reset_ctrl got cur=%0d swp=%b rej=%b want 0 0 0", bus.current_pipeline,
                  bus.swapping, bus.swap_rejected);
      end
      rst_n = 1'b1;
   endtask

   task automatic test_input_unity();
      logic [15:0] vec [3] = '{16'h0100, 16'hFFFB, 16'h7FFF};
      @(negedge clk);
      bus.in_sample = 16'h1234;
      bus.in_valid = 1'b1;
      @(negedge clk);
      bus.in_valid = 1'b0;
      n_checks++;
      if (bus.in_out_valid !== 1'b0) begin
         n_errors++;
         $display("FAIL in_latency_early got iv=%b want 0", bus.in_out_valid);
      end
      @(negedge clk);
      n_checks++;
      if (bus.in_out_valid !== 1'b1 || bus.in_sample_out !== 16'h1234) begin
         n_errors++;
         $display("FAIL in_unity got iv=%b %h want 1 1234", bus.in_out_valid, bus.in_sample_out);
      end
      @(negedge clk);
      n_checks++;
      if (bus.in_out_valid !== 1'b0) begin
         n_errors++;
         $display("FAIL in_pulse got iv=%b want 0", bus.in_out_valid);
      end
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         if (i >= 2) begin
            n_checks++;
            if (bus.in_out_valid !== 1'b1 || bus.in_sample_out !== vec[i-2]) begin
               n_errors++;
               $display("FAIL in_b2b[%0d] got iv=%b %h want 1 %h", i - 2, bus.in_out_valid,
                        bus.in_sample_out, vec[i-2]);
            end
         end
         bus.in_valid = (i < 3);
         if (i < 3) bus.in_sample = vec[i];
      end
      bus.in_valid = 1'b0;
   endtask

   task automatic test_output_unity();
      set_pipes(16'hFED4, 16'd7, 16'd9);
      @(negedge clk);
      bus.pipes_valid = 1'b1;
      @(negedge clk);
      bus.pipes_valid = 1'b0;
      @(negedge clk);
      n_checks++;
      if (bus.out_valid !== 1'b0) begin
         n_errors++;
         $display("FAIL out_latency_early got ov=%b want 0", bus.out_valid);
      end
      @(negedge clk);
      n_checks++;
      if (bus.out_valid !== 1'b1 || bus.out_sample !== 16'hFED4) begin
         n_errors++;
         $display("FAIL out_unity got ov=%b %0d want 1 -300", bus.out_valid, $signed(bus.out_sample));
      end
      @(negedge clk);
      n_checks++;
      if (bus.out_valid !== 1'b0) begin
         n_errors++;
         $display("FAIL out_pulse got ov=%b want 0", bus.out_valid);
      end
   endtask

   task automatic test_input_gain();
      logic [15:0] vec [3] = '{16'h3000, 16'hC000, 16'h0100};
      logic [15:0] exp [3] = '{16'h7FFF, 16'h8000, 16'h0400};
      load_gains(16'd4096, 1'b1, 1'b0);
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         if (i >= 2) begin
            n_checks++;
            if (bus.in_out_valid !== 1'b1 || bus.in_sample_out !== exp[i-2]) begin
               n_errors++;
               $display("FAIL in_gain4x[%0d] got iv=%b %h want 1 %h", i - 2, bus.in_out_valid,
                        bus.in_sample_out, exp[i-2]);
            end
         end
         bus.in_valid = (i < 3);
         if (i < 3) bus.in_sample = vec[i];
      end
      bus.in_valid = 1'b0;
      // Gain load coincident with a sample: that sample keeps 4x.
      @(negedge clk);
      bus.in_sample = 16'h0100;
      bus.in_valid = 1'b1;
      bus.gain_data = 16'd1024;
      bus.set_input_gain = 1'b1;
      @(negedge clk);
      bus.set_input_gain = 1'b0;
      @(negedge clk);
      bus.in_valid = 1'b0;
      n_checks++;
      if (bus.in_out_valid !== 1'b1 || bus.in_sample_out !== 16'h0400) begin
         n_errors++;
         $display("FAIL in_gain_same_cycle got iv=%b %h want 1 0400", bus.in_out_valid,
                  bus.in_sample_out);
      end
      @(negedge clk);
      n_checks++;
      if (bus.in_out_valid !== 1'b1 || bus.in_sample_out !== 16'h0100) begin
         n_errors++;
         $display("FAIL in_gain_next got iv=%b %h want 1 0100", bus.in_out_valid, bus.in_sample_out);
      end
   endtask

   task automatic test_output_gain();
      set_pipes(16'd800, 16'd0, 16'd0);
      @(negedge clk);
      bus.pipes_valid = 1'b1;
      bus.gain_data = 16'd512;
      bus.set_output_gain = 1'b1;
      @(negedge clk);
      bus.set_output_gain = 1'b0;
      @(negedge clk);
      bus.pipes_valid = 1'b0;
      @(negedge clk);
      n_checks++;
      if (bus.out_valid !== 1'b1 || bus.out_sample !== 16'd800) begin
         n_errors++;
         $display("FAIL out_gain_same_cycle got ov=%b %0d want 1 800", bus.out_valid,
                  $signed(bus.out_sample));
      end
      @(negedge clk);
      n_checks++;
      if (bus.out_valid !== 1'b1 || bus.out_sample !== 16'd400) begin
         n_errors++;
         $display("FAIL out_gain_half got ov=%b %0d want 1 400", bus.out_valid,
                  $signed(bus.out_sample));
      end
      load_gains(16'd2048, 1'b1, 1'b1);
      in_shot(16'h0100, y, v);
      n_checks++;
      if (v !== 1'b1 || y !== 16'sh0200) begin
         n_errors++;
         $display("FAIL both_gains_in got iv=%b %h want 1 0200", v, y);
      end
      pipe_shot(1'b0, 2'd0, y, v);
      n_checks++;
      if (v !== 1'b1 || y !== 16'sd1600) begin
         n_errors++;
         $display("FAIL both_gains_out got ov=%b %0d want 1 1600", v, y);
      end
      load_gains(16'd1024, 1'b1, 1'b1);
   endtask

   task automatic test_fade();
      logic signed [15:0] exp_f [4] = '{16'sd1000, 16'sd500, 16'sd0, -16'sd500};
      logic signed [15:0] exp_b [4] = '{-16'sd1000, -16'sd500, 16'sd0, 16'sd500};
      set_pipes(16'd1000, 16'd0, 16'hFC18);
      do_swap(2'd2);
      n_checks++;
      if (bus.swapping !== 1'b1 || bus.current_pipeline !== 2'd0 || bus.swap_rejected !== 1'b0) begin
         n_errors++;
         $display("FAIL fade_start got swp=%b cur=%0d rej=%b want 1 0 0", bus.swapping,
                  bus.current_pipeline, bus.swap_rejected);
      end
      bus.swap_req = 1'b1;
      bus.swap_target = 2'd1;
      @(negedge clk);
      bus.swap_req = 1'b0;
      n_checks++;
      if (bus.swap_rejected !== 1'b1) begin
         n_errors++;
         $display("FAIL fade_reject got rej=%b want 1", bus.swap_rejected);
      end
      @(negedge clk);
      n_checks++;
      if (bus.swap_rejected !== 1'b0 || bus.swapping !== 1'b1) begin
         n_errors++;
         $display("FAIL fade_reject_pulse got rej=%b swp=%b want 0 1", bus.swap_rejected, bus.swapping);
      end
      for (int i = 0; i < 4; i++) begin
         pipe_shot(1'b0, 2'd0, y, v);
         n_checks++;
         if (v !== 1'b1 || y !== exp_f[i]) begin
            n_errors++;
            $display("FAIL fade_k%0d got ov=%b %0d want 1 %0d", i, v, y, exp_f[i]);
         end
         if (i == 2) begin
            n_checks++;
            if (bus.swapping !== 1'b1 || bus.current_pipeline !== 2'd0) begin
               n_errors++;
               $display("FAIL fade_midway got swp=%b cur=%0d want 1 0", bus.swapping,
                        bus.current_pipeline);
            end
         end
      end
      n_checks++;
      if (bus.swapping !== 1'b0 || bus.current_pipeline !== 2'd2) begin
         n_errors++;
         $display("FAIL fade_done got swp=%b cur=%0d want 0 2", bus.swapping, bus.current_pipeline);
      end
      pipe_shot(1'b0, 2'd0, y, v);
      n_checks++;
      if (v !== 1'b1 || y !== -16'sd1000) begin
         n_errors++;
         $display("FAIL fade_after got ov=%b %0d want 1 -1000", v, y);
      end
      // Swap request alongside a sample: that sample stays on pipeline 2.
      pipe_shot(1'b1, 2'd0, y, v);
      n_checks++;
      if (v !== 1'b1 || y !== -16'sd1000) begin
         n_errors++;
         $display("FAIL swap_same_cycle got ov=%b %0d want 1 -1000", v, y);
      end
      for (int i = 0; i < 4; i++) begin
         pipe_shot(1'b0, 2'd0, y, v);
         n_checks++;
         if (v !== 1'b1 || y !== exp_b[i]) begin
            n_errors++;
            $display("FAIL fade_back_k%0d got ov=%b %0d want 1 %0d", i, v, y, exp_b[i]);
         end
      end
      n_checks++;
      if (bus.swapping !== 1'b0 || bus.current_pipeline !== 2'd0) begin
         n_errors++;
         $display("FAIL fade_back_done got swp=%b cur=%0d want 0 0", bus.swapping,
                  bus.current_pipeline);
      end
   endtask

   task automatic test_swap_noop_reject();
      do_swap(2'd0);
      n_checks++;
      if (bus.swap_rejected !== 1'b0 || bus.swapping !== 1'b0) begin
         n_errors++;
         $display("FAIL swap_noop got rej=%b swp=%b want 0 0", bus.swap_rejected, bus.swapping);
      end
      @(negedge clk);
      n_checks++;
      if (bus.swapping !== 1'b0 || bus.current_pipeline !== 2'd0) begin
         n_errors++;
         $display("FAIL swap_noop_hold got swp=%b cur=%0d want 0 0", bus.swapping,
                  bus.current_pipeline);
      end
      do_swap(2'd3);
      n_checks++;
      if (bus.swap_rejected !== 1'b1 || bus.swapping !== 1'b0) begin
         n_errors++;
         $display("FAIL swap_oob got rej=%b swp=%b want 1 0", bus.swap_rejected, bus.swapping);
      end
      @(negedge clk);
      n_checks++;
      if (bus.swap_rejected !== 1'b0) begin
         n_errors++;
         $display("FAIL swap_oob_pulse got rej=%b want 0", bus.swap_rejected);
      end
   endtask

   task automatic test_reset_mid_fade();
      logic signed [15:0] exp_f [4] = '{16'sd2000, 16'sd1600, 16'sd1200, 16'sd800};
      int seen;
      load_gains(16'd2048, 1'b1, 1'b1);
      set_pipes(16'd1000, 16'd200, 16'hFC18);
      do_swap(2'd1);
      for (int i = 0; i < 4; i++) begin
         pipe_shot(1'b0, 2'd0, y, v);
         n_checks++;
         if (v !== 1'b1 || y !== exp_f[i]) begin
            n_errors++;
            $display("FAIL gain2x_fade_k%0d got ov=%b %0d want 1 %0d", i, v, y, exp_f[i]);
         end
      end
      n_checks++;
      if (bus.current_pipeline !== 2'd1) begin
         n_errors++;
         $display("FAIL gain2x_fade_done got cur=%0d want 1", bus.current_pipeline);
      end
      do_swap(2'd2);
      pipe_shot(1'b0, 2'd0, y, v);
      n_checks++;
      if (v !== 1'b1 || y !== 16'sd400) begin
         n_errors++;
         $display("FAIL rst_fade_k0 got ov=%b %0d want 1 400", v, y);
      end
      pipe_shot(1'b0, 2'd0, y, v);
      n_checks++;
      if (v !== 1'b1 || y !== -16'sd200) begin
         n_errors++;
         $display("FAIL rst_fade_k1 got ov=%b %0d want 1 -200", v, y);
      end
      @(negedge clk);
      bus.pipes_valid = 1'b1;
      @(negedge clk);
      bus.pipes_valid = 1'b0;
      bus.in_sample = 16'h0100;
      bus.in_valid = 1'b1;
      @(negedge clk);
      bus.in_valid = 1'b0;
      rst_n = 1'b0;
      #1;
      n_checks++;
      if (bus.out_sample !== 16'h0 || bus.out_valid !== 1'b0 || bus.in_sample_out !== 16'h0 ||
          bus.in_out_valid !== 1'b0 || bus.current_pipeline !== 2'd0 || bus.swapping !== 1'b0) begin
         n_errors++;
         $display("FAIL mid_fade_reset got out=%h ov=%b in=%h iv=%b cur=%0d swp=%b want all 0",
                  bus.out_sample, bus.out_valid, bus.in_sample_out, bus.in_out_valid,
                  bus.current_pipeline, bus.swapping);
      end
      @(negedge clk);
      rst_n = 1'b1;
      seen = 0;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         if (bus.out_valid === 1'b1 || bus.in_out_valid === 1'b1) seen++;
      end
      n_checks++;
      if (seen != 0) begin
         n_errors++;
         $display("FAIL inflight_discard got %0d valid cycles want 0", seen);
      end
      pipe_shot(1'b0, 2'd0, y, v);
      n_checks++;
      if (v !== 1'b1 || y !== 16'sd1000 || bus.swapping !== 1'b0) begin
         n_errors++;
         $display("FAIL post_reset_out got ov=%b %0d swp=%b want 1 1000 0", v, y, bus.swapping);
      end
      in_shot(16'h0100, y, v);
      n_checks++;
      if (v !== 1'b1 || y !== 16'sh0100) begin
         n_errors++;
         $display("FAIL post_reset_in got iv=%b %h want 1 0100", v, y);
      end
   endtask

   initial begin
      bus.in_sample = '0;
      bus.in_valid = 1'b0;
      bus.pipe_samples = '0;
      bus.pipes_valid = 1'b0;
      bus.gain_data = '0;
      bus.set_input_gain = 1'b0;
      bus.set_output_gain = 1'b0;
      bus.swap_req = 1'b0;
      bus.swap_target = '0;
      test_reset();
      test_input_unity();
      test_output_unity();
      test_input_gain();
      test_output_gain();
      test_fade();
      test_swap_noop_reject();
      test_reset_mid_fade();
      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
